// File: rtl/xbar_link_pkg.sv
// Shared constants, link register state type and parity helper for the crossbar link transmitter.
package xbar_link_pkg;

  localparam int LINK_DATA_W = 8;

  localparam logic SEL_CH0 = 1'b0;
  localparam logic SEL_CH1 = 1'b1;

  typedef enum logic {
    LINK_EMPTY = 1'b0,
    LINK_HELD  = 1'b1
  } link_state_e;

  // Odd parity bit: zero-extension does not change the ones count, so one width serves all callers.
  function automatic logic odd_parity(input logic [63:0] vec);
    return ~^vec;
  endfunction

endpackage

// File: rtl/xbar_link_tx_fifo.sv
// Per-channel byte FIFO: power-of-two depth, wrapping pointers, occupancy counter,
// simultaneous push and pop allowed.
module link_fifo
  import xbar_link_pkg::*;
#(
  parameter int DATA_W     = LINK_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == {CNT_W{1'b0}});
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;

    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes every entry so nothing stale can resurface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xbar_link_tx.sv
// Crossbar link transmitter: two channel FIFOs, round-robin arbiter, registered link output.
// Optional odd-parity output enabled by defining LINK_PARITY_EN.
module xbar_link_tx
  import xbar_link_pkg::*;
#(
  parameter int DATA_W     = LINK_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  output logic [DATA_W-1:0] link_data,
  output logic              link_sel,
  output logic              link_valid,
  input  logic              link_ready
`ifdef LINK_PARITY_EN
  ,
  output logic              link_parity
`endif
);

  logic              full0_s, empty0_s, pop0_s, push0_s;
  logic              full1_s, empty1_s, pop1_s, push1_s;
  logic [DATA_W-1:0] head0_s, head1_s;
  logic              load_s;
  logic              load_sel_s;

  link_state_e       state_q, state_d;
  logic [DATA_W-1:0] link_data_q, link_data_d;
  logic              link_sel_q, link_sel_d;
  logic              rr_last_q, rr_last_d;
`ifdef LINK_PARITY_EN
  logic              link_parity_q, link_parity_d;
`endif

  // Ready ignores any same-cycle pop and is held low throughout reset.
  assign ch0_ready = rst_n && !full0_s;
  assign ch1_ready = rst_n && !full1_s;
  assign push0_s   = ch0_valid && ch0_ready;
  assign push1_s   = ch1_valid && ch1_ready;
  assign pop0_s    = load_s && (load_sel_s == SEL_CH0);
  assign pop1_s    = load_s && (load_sel_s == SEL_CH1);

  link_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .push_data (ch0_data),
    .pop       (pop0_s),
    .full      (full0_s),
    .empty     (empty0_s),
    .head      (head0_s)
  );

  link_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .push_data (ch1_data),
    .pop       (pop1_s),
    .full      (full1_s),
    .empty     (empty1_s),
    .head      (head1_s)
  );

  // Arbiter: load whenever the link register is free or draining; ties go away from rr_last.
  always_comb begin
    load_s     = 1'b0;
    load_sel_s = SEL_CH0;
    if ((state_q == LINK_EMPTY) || link_ready) begin
      if (!empty0_s && !empty1_s) begin
        load_s     = 1'b1;
        load_sel_s = (rr_last_q == SEL_CH0) ? SEL_CH1 : SEL_CH0;
      end else if (!empty0_s) begin
        load_s     = 1'b1;
        load_sel_s = SEL_CH0;
      end else if (!empty1_s) begin
        load_s     = 1'b1;
        load_sel_s = SEL_CH1;
      end else begin
        load_s     = 1'b0;
        load_sel_s = SEL_CH0;
      end
    end else begin
      load_s     = 1'b0;
      load_sel_s = SEL_CH0;
    end
  end

  // Link register next state: load, drain to empty, or hold under backpressure.
  always_comb begin
    state_d       = state_q;
    link_data_d   = link_data_q;
    link_sel_d    = link_sel_q;
    rr_last_d     = rr_last_q;
`ifdef LINK_PARITY_EN
    link_parity_d = link_parity_q;
`endif
    case (state_q)
      LINK_EMPTY, LINK_HELD: begin
        if (load_s) begin
          state_d       = LINK_HELD;
          link_data_d   = (load_sel_s == SEL_CH1) ? head1_s : head0_s;
          link_sel_d    = load_sel_s;
          rr_last_d     = load_sel_s;
`ifdef LINK_PARITY_EN
          link_parity_d = odd_parity(64'({load_sel_s, link_data_d}));
`endif
        end else if ((state_q == LINK_HELD) && link_ready) begin
          state_d       = LINK_EMPTY;
`ifdef LINK_PARITY_EN
          link_parity_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = LINK_EMPTY;
      end
    endcase
  end

  // Link output and arbitration-history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LINK_EMPTY;
      link_data_q   <= {DATA_W{1'b0}};
      link_sel_q    <= SEL_CH0;
      rr_last_q     <= SEL_CH1;
`ifdef LINK_PARITY_EN
      link_parity_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      link_data_q   <= link_data_d;
      link_sel_q    <= link_sel_d;
      rr_last_q     <= rr_last_d;
`ifdef LINK_PARITY_EN
      link_parity_q <= link_parity_d;
`endif
    end
  end

  assign link_valid = (state_q == LINK_HELD);
  assign link_data  = link_data_q;
  assign link_sel   = link_sel_q;
`ifdef LINK_PARITY_EN
  assign link_parity = link_parity_q;
`endif

endmodule

// File: tb/tb_xbar_link_tx.sv
// Self-checking bench for xbar_link_tx: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_xbar_link_tx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch0_data, ch1_data;
  logic       ch0_valid, ch1_valid;
  logic       ch0_ready, ch1_ready;
  logic [7:0] link_data;
  logic       link_sel, link_valid, link_ready;
`ifdef LINK_PARITY_EN
  logic       link_parity;
`endif

  always #5 clk = ~clk;

  xbar_link_tx #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch0_data   (ch0_data),
    .ch0_valid  (ch0_valid),
    .ch0_ready  (ch0_ready),
    .ch1_data   (ch1_data),
    .ch1_valid  (ch1_valid),
    .ch1_ready  (ch1_ready),
    .link_data  (link_data),
    .link_sel   (link_sel),
    .link_valid (link_valid),
    .link_ready (link_ready)
`ifdef LINK_PARITY_EN
    ,
    .link_parity(link_parity)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued bytes per channel plus what the link currently shows.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         m_hv = 1'b0;
  logic [7:0] m_hd = 8'h00;
  bit         m_hs = 1'b0;
  bit         m_rr = 1'b1;
  bit         acc0 = 1'b0;
  bit         acc1 = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: apply the rules to the model, then compare the DUT after the edge.
  task automatic tick();
    acc0 = rst_n && ch0_valid && (mq0.size() < DEPTH);
    acc1 = rst_n && ch1_valid && (mq1.size() < DEPTH);
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      m_hv = 1'b0;
      m_hd = 8'h00;
      m_hs = 1'b0;
      m_rr = 1'b1;
    end else begin
      if ((!m_hv || link_ready) && (mq0.size() + mq1.size() > 0)) begin
        bit ch;
        if (mq0.size() > 0 && mq1.size() > 0) ch = !m_rr;
        else ch = (mq0.size() == 0);
        m_hd = ch ? mq1.pop_front() : mq0.pop_front();
        m_hs = ch;
        m_rr = ch;
        m_hv = 1'b1;
      end else if (m_hv && link_ready) begin
        m_hv = 1'b0;
      end
      if (acc0) mq0.push_back(ch0_data);
      if (acc1) mq1.push_back(ch1_data);
    end
    @(posedge clk);
    #1;
    check_value("ch0_ready", 32'(ch0_ready), 32'(rst_n && (mq0.size() < DEPTH)));
    check_value("ch1_ready", 32'(ch1_ready), 32'(rst_n && (mq1.size() < DEPTH)));
    check_value("link_valid", 32'(link_valid), 32'(m_hv));
    if (m_hv) begin
      check_value("link_data", 32'(link_data), 32'(m_hd));
      check_value("link_sel", 32'(link_sel), 32'(m_hs));
    end
`ifdef LINK_PARITY_EN
    check_value("link_parity", 32'(link_parity),
                32'(m_hv && ($countones({m_hs, m_hd}) % 2 == 0)));
`endif
  endtask

  task automatic send(input bit ch, input logic [7:0] d);
    int guard = 0;
    if (ch) begin ch1_valid = 1'b1; ch1_data = d; end
    else begin ch0_valid = 1'b1; ch0_data = d; end
    do begin
      tick();
      guard++;
    end while (!(ch ? acc1 : acc0) && guard < 20);
    if (!(ch ? acc1 : acc0)) check_value("send_timeout", 32'd0, 32'd1);
    if (ch) ch1_valid = 1'b0;
    else ch0_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr_data [4];
    logic       rr_sel  [4];
    logic [7:0] fill    [5];
    int         bp;

    rst_n = 1'b0; link_ready = 1'b0;
    ch0_valid = 1'b1; ch0_data = 8'h11;
    ch1_valid = 1'b0; ch1_data = 8'h00;

    // Reset with a producer already asserting valid.
    tick();
    tick();
    check_value("rst_ch0_ready", 32'(ch0_ready), 32'd0);
    check_value("rst_link_valid", 32'(link_valid), 32'd0);
    check_value("rst_link_data", 32'(link_data), 32'h00);
    check_value("rst_link_sel", 32'(link_sel), 32'd0);
    ch0_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_value("rel_ch0_ready", 32'(ch0_ready), 32'd1);
    tick();
    tick();

    // Single byte with two-edge latency.
    link_ready = 1'b1;
    send(1'b0, 8'hAB);
    tick();
    check_value("single_valid", 32'(link_valid), 32'd1);
    check_value("single_data", 32'(link_data), 32'hAB);
    check_value("single_sel", 32'(link_sel), 32'd0);
    tick();
    check_value("single_drop", 32'(link_valid), 32'd0);

    // Round-robin with both FIFOs loaded.
    do_reset();
    link_ready = 1'b0;
    ch0_valid = 1'b1; ch0_data = 8'h08;
    ch1_valid = 1'b1; ch1_data = 8'hBB;
    tick();
    ch0_data = 8'hF2; ch1_data = 8'h90;
    tick();
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    rr_data = '{8'h08, 8'hBB, 8'hF2, 8'h90};
    rr_sel  = '{1'b0, 1'b1, 1'b0, 1'b1};
    check_value("rr_data0", 32'(link_data), 32'(rr_data[0]));
    check_value("rr_sel0", 32'(link_sel), 32'(rr_sel[0]));
    link_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_value("rr_valid", 32'(link_valid), 32'd1);
      check_value("rr_data", 32'(link_data), 32'(rr_data[i]));
      check_value("rr_sel", 32'(link_sel), 32'(rr_sel[i]));
    end
    tick();
    check_value("rr_idle", 32'(link_valid), 32'd0);

    // Backpressure fills channel 1.
    link_ready = 1'b0;
    fill = '{8'hC3, 8'h54, 8'h49, 8'h4E, 8'hB1};
    for (int i = 0; i < 5; i++) send(1'b1, fill[i]);
    check_value("full_ready", 32'(ch1_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_value("held_data", 32'(link_data), 32'hC3);
    end
    link_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check_value("drain_data", 32'(link_data), 32'(fill[i]));
      check_value("drain_ready", 32'(ch1_ready), 32'd1);
    end
    tick();
    check_value("drain_idle", 32'(link_valid), 32'd0);

    // Reset mid-operation discards link and FIFO contents.
    link_ready = 1'b0;
    send(1'b0, 8'h67);
    send(1'b0, 8'hFF);
    send(1'b0, 8'h3B);
    check_value("mid_held", 32'(link_data), 32'h67);
    do_reset();
    check_value("mid_rst_valid", 32'(link_valid), 32'd0);
    link_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_value("mid_no_stale", 32'(link_valid), 32'd0);
    end

`ifdef LINK_PARITY_EN
    send(1'b1, 8'h00);
    tick();
    check_value("par_sel1_00", 32'(link_parity), 32'd0);
    send(1'b0, 8'hA9);
    tick();
    check_value("par_sel0_a9", 32'(link_parity), 32'd1);
`endif

    // Randomized traffic with alternating light and heavy backpressure, rare resets.
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (acc0 || !ch0_valid) begin
        ch0_valid = ($urandom_range(0, 99) < 60);
        ch0_data  = 8'($urandom);
      end
      if (acc1 || !ch1_valid) begin
        ch1_valid = ($urandom_range(0, 99) < 60);
        ch1_data  = 8'($urandom);
      end
      bp = ((i / 500) % 2 == 1) ? 30 : 90;
      link_ready = ($urandom_range(0, 99) < bp);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
